traceback_decoder: RTL and testbench
====================================

// Module: traceback_decoder
// PURPOSE
//  Consumer end of the Grid traceback coordinate stream. Takes (x,y) cells from (LENGTH-1,LENGTH-1) down to (0,0).
//  Each cell is one grid coordinate: x indexes s2 and y indexes s1.
//  Decodes every step into an aligned character pair with gap flags, and streams the pairs out over valid/ready.
//  Accumulates the alignment score and the match/mismatch/indel counts. Sits between Grid and the result sink.
// PARAMETERS
//  LENGTH       10  characters per string; grid is LENGTH x LENGTH
//  CWIDTH        2  bits per character
//  SWIDTH       16  bits per score (signed)
//  CORD_LENGTH   8  bits per coordinate
//  MATCH         1  weight for an equal diagonal pair (signed)
//  MISMATCH     -1  weight for an unequal diagonal pair (signed)
//  INDEL        -1  weight for a gap pair (signed)
// PORTS
//  clk        in   1               single clock; all state on posedge
//  reset      in   1               synchronous, active-low: reset==0 clears state on the next posedge
//  start      in   1               one-cycle pulse: arm for a new path (legal in any state)
//  s1, s2     in   LENGTH*CWIDTH   packed strings; char i = s[((LENGTH-1)-i)*CWIDTH +: CWIDTH]
//  in_valid   in   1               coordinate present on in_x/in_y
//  in_ready   out  1               coordinate accepted when in_valid && in_ready
//  in_x,in_y  in   CORD_LENGTH     traceback coordinate
//  out_valid  out  1               aligned pair present
//  out_ready  in   1               pair consumed when out_valid && out_ready
//  out_c1     out  CWIDTH          s1 character (0 when out_gap1)
//  out_c2     out  CWIDTH          s2 character (0 when out_gap2)
//  out_gap1   out  1               gap in s1
//  out_gap2   out  1               gap in s2
//  out_last   out  1               final pair of the path
//  score      out  SWIDTH          running signed alignment score
//  n_match, n_mismatch, n_indel  out CORD_LENGTH+1  running counts
//  done       out  1               path complete; score/counts final
//  error      out  1               illegal coordinate seen
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE.
//  FSM: IDLE -start-> FIRST -accept-> RUN -accept (0,0)-> TERM -pair taken-> DONE -start-> FIRST.
//   Any state -illegal coord-> ERR. ERR/DONE -start-> FIRST.
//   A start pulse in any state clears score, counts, done, error and out_valid, then enters FIRST.
//  in_ready = (state==FIRST || state==RUN) && (!out_valid || out_ready). It is 0 in IDLE, TERM, DONE and ERR.
//  FIRST: the accepted coordinate must be (LENGTH-1,LENGTH-1). It is latched as prev and emits no pair.
//  RUN: each accepted coordinate (x,y) is checked against prev (px,py):
//   dx=1,dy=1: pair (s1[py],s2[px]). Adds MATCH if the characters are equal, else MISMATCH.
//   dx=0,dy=1: up step. Pair (s1[py],gap), out_gap2=1, adds INDEL.
//   dx=1,dy=0: left step. Pair (gap,s2[px]), out_gap1=1, adds INDEL.
//   Any other delta, or x/y>=LENGTH: error=1, go to ERR. No pair is emitted and the counters are held.
//  Accepting (0,0) goes to TERM. TERM emits (s1[0],s2[0]) scored as a diagonal with out_last=1.
//   done=1 the cycle after that pair is taken.
//  Output register: pair, score and counts update on the accepting edge, so latency is 1 cycle from accept to out_valid.
//   Output data is held stable while out_valid && !out_ready.
//  Score is sign-extended, wraps mod 2^SWIDTH with no saturation. Counts are max 2*LENGTH-1.
//  A full mismatch path is LENGTH pairs. The longest path is 2*LENGTH-1 pairs.
// CONFIGURATION
//  TB_SCORE_CHECK_EN defined: adds input exp_score[SWIDTH] and output score_ok.
//   score_ok = done && (score==exp_score). It is reset to 0 and cleared by start.
//  TB_SCORE_CHECK_EN undefined: the port and its logic are absent. All other behaviour is identical.
// TESTING (LENGTH=4, default weights)
//  T1: s1=s2={0,1,2,3}, coords (3,3),(2,2),(1,1),(0,0) -> 4 pairs (3,3),(2,2),(1,1),(0,0), last on the 4th.
//      Expect score=4, n_match=4, done=1.
//  T2: s1={0,1,2,3}, s2={0,1,2,0}, coords (3,3),(2,3),(1,2),(0,1),(0,0).
//      Pairs: (gap,s2[3]), (s1[3],s2[2]), (s1[2],s2[1]), (s1[1],gap), (s1[0],s2[0]).
//      Expect score=-1-1-1-1+1=-3, n_indel=2, n_mismatch=2, n_match=1.
//  T3: coords (3,3) then (1,1) -> error=1, in_ready=0, no out_valid. A start pulse then clears error.
//  T4: T1 with out_ready=0 for 3 cycles after the first pair -> out_c1/out_c2 are stable.
//      in_ready=0 for those cycles and no coordinate is lost.
//  T5: reset=0 for one cycle mid-T2 -> all outputs 0 and IDLE. T1 afterwards passes unchanged.
//  T6: TB_SCORE_CHECK_EN with exp_score=4 -> T1 gives score_ok=1. With exp_score=3 -> score_ok=0.

Source files
------------

// File: rtl/traceback_decoder.sv
// Decodes a Grid traceback coordinate stream into aligned character pairs and accumulates the score/counts.
// Optional TB_SCORE_CHECK_EN adds exp_score input and score_ok output.
module traceback_decoder #(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int SWIDTH      = 16,
  parameter int CORD_LENGTH = 8,
  parameter int MATCH       = 1,
  parameter int MISMATCH    = -1,
  parameter int INDEL       = -1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [LENGTH*CWIDTH-1:0]      s1,
  input  logic [LENGTH*CWIDTH-1:0]      s2,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CORD_LENGTH-1:0]        in_x,
  input  logic [CORD_LENGTH-1:0]        in_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CWIDTH-1:0]             out_c1,
  output logic [CWIDTH-1:0]             out_c2,
  output logic                          out_gap1,
  output logic                          out_gap2,
  output logic                          out_last,
  output logic signed [SWIDTH-1:0]      score,
  output logic [CORD_LENGTH:0]          n_match,
  output logic [CORD_LENGTH:0]          n_mismatch,
  output logic [CORD_LENGTH:0]          n_indel,
  output logic                          done,
  output logic                          error
`ifdef TB_SCORE_CHECK_EN
  ,
  input  logic signed [SWIDTH-1:0]      exp_score,
  output logic                          score_ok
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FIRST, S_RUN, S_TERM, S_DONE, S_ERR} state_t;

  localparam logic [CORD_LENGTH-1:0] LAST = CORD_LENGTH'(LENGTH - 1);
  localparam logic [CORD_LENGTH:0]   ONE  = (CORD_LENGTH + 1)'(1);

  function automatic logic [CWIDTH-1:0] get_char(input logic [LENGTH*CWIDTH-1:0] s,
                                                 input logic [CORD_LENGTH-1:0]   idx);
    logic [CWIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < LENGTH; i++)
      if (idx == CORD_LENGTH'(i)) c = s[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
    return c;
  endfunction

  function automatic logic signed [SWIDTH-1:0] pair_weight(input logic gap, input logic eq);
    if (gap) return SWIDTH'(INDEL);
    else if (eq) return SWIDTH'(MATCH);
    else return SWIDTH'(MISMATCH);
  endfunction

  // Score wraps modulo 2^SWIDTH; no saturation.
  function automatic logic signed [SWIDTH-1:0] wrap_add(input logic signed [SWIDTH-1:0] a,
                                                        input logic signed [SWIDTH-1:0] b);
    return a + b;
  endfunction

  state_t r_state, r_next;
  logic [CORD_LENGTH-1:0] r_px, r_py;
  logic                   r_vld_p1, r_last_p1, r_g1_p1, r_g2_p1;
  logic [CWIDTH-1:0]      r_c1_p1, r_c2_p1;
  logic signed [SWIDTH-1:0] r_score;
  logic [CORD_LENGTH:0]   r_nm, r_nmm, r_ni;
  logic                   r_done, r_error;

  logic                   w_slot_free, w_accept, w_first_ok, w_run_ok, w_bad, w_zero;
  logic                   w_diag, w_up, w_left, w_in_range;
  logic                   w_term_load, w_term_take, w_emit, w_g1, w_g2;
  logic [CWIDTH-1:0]      w_c1, w_c2;
  logic [CORD_LENGTH:0]   w_x1, w_y1, w_px, w_py;

  assign w_slot_free = !r_vld_p1 || out_ready;
  assign in_ready    = ((r_state == S_FIRST) || (r_state == S_RUN)) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  // Step classification: the new coordinate is compared to the previously accepted one.
  assign w_x1       = {1'b0, in_x} + ONE;
  assign w_y1       = {1'b0, in_y} + ONE;
  assign w_px       = {1'b0, r_px};
  assign w_py       = {1'b0, r_py};
  assign w_diag     = (w_x1 == w_px) && (w_y1 == w_py);
  assign w_up       = (in_x == r_px) && (w_y1 == w_py);
  assign w_left     = (w_x1 == w_px) && (in_y == r_py);
  assign w_in_range = (in_x <= LAST) && (in_y <= LAST);
  assign w_first_ok = (in_x == LAST) && (in_y == LAST);
  assign w_run_ok   = w_in_range && (w_diag || w_up || w_left);
  assign w_zero     = (in_x == '0) && (in_y == '0);
  assign w_bad      = w_accept && (((r_state == S_FIRST) && !w_first_ok) ||
                                   ((r_state == S_RUN) && !w_run_ok));

  // Once in TERM, prev is (0,0), so the final pair is simply the diagonal at prev.
  assign w_term_load = (r_state == S_TERM) && !(r_vld_p1 && r_last_p1) && w_slot_free;
  assign w_term_take = (r_state == S_TERM) && r_vld_p1 && r_last_p1 && out_ready;
  assign w_emit      = (w_accept && (r_state == S_RUN) && w_run_ok) || w_term_load;

  assign w_g1 = (r_state == S_RUN) && w_left;
  assign w_g2 = (r_state == S_RUN) && w_up;
  assign w_c1 = w_g1 ? '0 : get_char(s1, r_py);
  assign w_c2 = w_g2 ? '0 : get_char(s2, r_px);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    if (start) r_next = S_FIRST;
    else begin
      case (r_state)
        S_FIRST: if (w_accept) r_next = w_first_ok ? S_RUN : S_ERR;
        S_RUN:   if (w_accept) r_next = !w_run_ok ? S_ERR : (w_zero ? S_TERM : S_RUN);
        S_TERM:  if (w_term_take) r_next = S_DONE;
        default: r_next = r_state;
      endcase
    end
  end

  // Output register stage: pair, score and counts update on the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset || start) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_g1_p1   <= 1'b0;
      r_g2_p1   <= 1'b0;
      r_c1_p1   <= '0;
      r_c2_p1   <= '0;
      r_score   <= '0;
      r_nm      <= '0;
      r_nmm     <= '0;
      r_ni      <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_bad) r_error <= 1'b1;
      if (w_emit) begin
        r_vld_p1  <= 1'b1;
        r_last_p1 <= (r_state == S_TERM);
        r_g1_p1   <= w_g1;
        r_g2_p1   <= w_g2;
        r_c1_p1   <= w_c1;
        r_c2_p1   <= w_c2;
        r_score   <= wrap_add(r_score, pair_weight(w_g1 || w_g2, w_c1 == w_c2));
        if (w_g1 || w_g2)     r_ni  <= r_ni + ONE;
        else if (w_c1 == w_c2) r_nm  <= r_nm + ONE;
        else                  r_nmm <= r_nmm + ONE;
      end else if (out_ready) begin
        r_vld_p1 <= 1'b0;
      end
      if (w_term_take) r_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_bad && !start) begin
      r_px <= in_x;
      r_py <= in_y;
    end
  end

  assign out_valid  = r_vld_p1;
  assign out_c1     = r_c1_p1;
  assign out_c2     = r_c2_p1;
  assign out_gap1   = r_g1_p1;
  assign out_gap2   = r_g2_p1;
  assign out_last   = r_last_p1;
  assign score      = r_score;
  assign n_match    = r_nm;
  assign n_mismatch = r_nmm;
  assign n_indel    = r_ni;
  assign done       = r_done;
  assign error      = r_error;

`ifdef TB_SCORE_CHECK_EN
  assign score_ok = r_done && (r_score == exp_score);
`endif

endmodule

// File: tb/tb_traceback_decoder.sv
// Randomized and directed bench for traceback_decoder (LENGTH=4) against a path-list reference model.
module tb_traceback_decoder;

  typedef struct packed {
    logic [1:0] c1;
    logic [1:0] c2;
    logic       g1;
    logic       g2;
    logic       last;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] s1 = '0, s2 = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_x = '0, in_y = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [1:0] out_c1, out_c2;
  logic out_gap1, out_gap2, out_last;
  logic signed [15:0] score;
  logic [8:0] n_match, n_mismatch, n_indel;
  logic done, error;
`ifdef TB_SCORE_CHECK_EN
  logic signed [15:0] exp_score = '0;
  logic score_ok;
`endif

  traceback_decoder #(.LENGTH(4), .CWIDTH(2), .SWIDTH(16), .CORD_LENGTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_c1(out_c1), .out_c2(out_c2),
    .out_gap1(out_gap1), .out_gap2(out_gap2), .out_last(out_last), .score(score),
    .n_match(n_match), .n_mismatch(n_mismatch), .n_indel(n_indel),
    .done(done), .error(error)
`ifdef TB_SCORE_CHECK_EN
    , .exp_score(exp_score), .score_ok(score_ok)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] a1[4], a2[4];
  int cx[$], cy[$];
  pair_t exp_q[$];
  int exp_err, e_score, e_m, e_mm, e_id;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_str(input logic [7:0] p1, input logic [7:0] p2);
    s1 = p1;
    s2 = p2;
    for (int i = 0; i < 4; i++) begin
      a1[i] = p1[(3-i)*2 +: 2];
      a2[i] = p2[(3-i)*2 +: 2];
    end
  endtask

  function automatic void add_pair(input pair_t p);
    exp_q.push_back(p);
    if (p.g1 || p.g2) begin e_id++; e_score -= 1; end
    else if (p.c1 == p.c2) begin e_m++; e_score += 1; end
    else begin e_mm++; e_score -= 1; end
  endfunction

  // Walks the coordinate list and lists every pair the decoder should produce.
  function automatic void build_model();
    int px, py;
    pair_t p;
    exp_q.delete();
    exp_err = 0; e_score = 0; e_m = 0; e_mm = 0; e_id = 0;
    if (cx[0] != 3 || cy[0] != 3) begin exp_err = 1; return; end
    px = 3; py = 3;
    for (int k = 1; k < cx.size(); k++) begin
      int dx, dy;
      dx = px - cx[k];
      dy = py - cy[k];
      if (cx[k] > 3 || cy[k] > 3 ||
          !((dx == 1 && dy == 1) || (dx == 0 && dy == 1) || (dx == 1 && dy == 0))) begin
        exp_err = 1;
        return;
      end
      p.g1 = (dy == 0);
      p.g2 = (dx == 0);
      p.c1 = p.g1 ? 2'd0 : a1[py];
      p.c2 = p.g2 ? 2'd0 : a2[px];
      p.last = 1'b0;
      add_pair(p);
      px = cx[k]; py = cy[k];
      if (px == 0 && py == 0) begin
        p.g1 = 1'b0; p.g2 = 1'b0; p.c1 = a1[0]; p.c2 = a2[0]; p.last = 1'b1;
        add_pair(p);
        return;
      end
    end
  endfunction

  function automatic void gen_path(input bit bad);
    int x, y, badk, r;
    x = 3; y = 3;
    cx.delete(); cy.delete();
    cx.push_back(3); cy.push_back(3);
    badk = $urandom_range(0, 5);
    if (bad && badk == 0) begin cx[0] = 2; return; end
    while (!(x == 0 && y == 0)) begin
      if (bad && cx.size() == badk) begin
        r = $urandom_range(0, 2);
        if (r == 0) begin cx.push_back(x); cy.push_back(y); end
        else if (r == 1) begin cx.push_back(x + 1); cy.push_back(y); end
        else begin cx.push_back(6); cy.push_back(y); end
        return;
      end
      r = $urandom_range(0, 2);
      if (x == 0) r = 1;
      if (y == 0) r = 2;
      if (r != 2) y--;
      if (r != 1) x--;
      cx.push_back(x); cy.push_back(y);
    end
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq("start_valid", int'(out_valid), 0);
    check_eq("start_done", int'(done), 0);
    check_eq("start_error", int'(error), 0);
    check_eq("start_score", int'(score), 0);
  endtask

  // mode 0: random valid/ready; 1: always valid/ready; 2: stall 3 cycles after first pair.
  task automatic run_path(input int mode, input int stop_at);
    int ci, got, cyc, stall, drain;
    bit fin, stall_done, hold_v;
    pair_t cur, hold_p;
    ci = 0; got = 0; cyc = 0; stall = 0; drain = 0;
    fin = 0; stall_done = 0; hold_v = 0;
    build_model();
    do_start();
    while (!fin) begin
      @(negedge clk);
      in_valid = (ci < cx.size()) && (mode != 0 || $urandom_range(0, 3) != 0);
      in_x = (ci < cx.size()) ? 8'(cx[ci]) : 8'd0;
      in_y = (ci < cx.size()) ? 8'(cy[ci]) : 8'd0;
      #1;
      if (mode == 2 && out_valid && !stall_done) begin stall = 3; stall_done = 1; end
      if (mode == 0) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = (stall == 0);
      if (exp_err != 0 && ci >= cx.size()) out_ready = 1'b1;
      #1;
      cur = '{c1: out_c1, c2: out_c2, g1: out_gap1, g2: out_gap2, last: out_last};
      if (hold_v) begin
        check_eq("hold_valid", int'(out_valid), 1);
        check_eq("hold_data", int'(cur), int'(hold_p));
      end
      if (stall > 0) begin
        check_eq("stall_in_ready", int'(in_ready), 0);
        stall--;
      end
      hold_v = out_valid && !out_ready;
      hold_p = cur;
      if (in_valid && in_ready) ci++;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) check_eq("pair", int'(cur), int'(exp_q[got]));
        else check_eq("extra_pair", 1, 0);
        got++;
      end
      cyc++;
      if (stop_at >= 0) begin
        if (ci >= stop_at) fin = 1;
      end else if (exp_err != 0) begin
        if (ci >= cx.size()) drain++;
        if (drain >= 6) fin = 1;
      end else if (done) begin
        fin = 1;
      end
      if (!fin && cyc >= 300) begin
        check_eq("timeout", 1, 0);
        fin = 1;
      end
    end
    in_valid = 1'b0;
    if (stop_at >= 0) return;
    check_eq("npairs", got, exp_q.size());
    check_eq("error", int'(error), exp_err);
    check_eq("score", int'(score), e_score);
    check_eq("n_match", int'(n_match), e_m);
    check_eq("n_mismatch", int'(n_mismatch), e_mm);
    check_eq("n_indel", int'(n_indel), e_id);
    check_eq("out_valid_end", int'(out_valid), 0);
    if (exp_err != 0) begin
      check_eq("err_in_ready", int'(in_ready), 0);
      check_eq("err_done", int'(done), 0);
    end else begin
      check_eq("done", int'(done), 1);
`ifdef TB_SCORE_CHECK_EN
      exp_score = 16'(e_score);
      #1 check_eq("score_ok_hit", int'(score_ok), 1);
      exp_score = 16'(e_score - 1);
      #1 check_eq("score_ok_miss", int'(score_ok), 0);
`endif
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_in_ready"}, int'(in_ready), 0);
    check_eq({tag, "_score"}, int'(score), 0);
    check_eq({tag, "_counts"}, int'(n_match) + int'(n_mismatch) + int'(n_indel), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_error"}, int'(error), 0);
    check_eq({tag, "_pair"}, int'({out_c1, out_c2, out_gap1, out_gap2, out_last}), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check_reset_state("reset");

    // T1: identical strings along the diagonal.
    set_str(8'h1B, 8'h1B);
    cx = '{3, 2, 1, 0}; cy = '{3, 2, 1, 0};
    run_path(1, -1);

    // T2: mixed gaps, mismatches and a final match.
    set_str(8'h1B, 8'h18);
    cx = '{3, 2, 1, 0, 0}; cy = '{3, 3, 2, 1, 0};
    run_path(1, -1);

    // T3: illegal jump, then start clears the error.
    cx = '{3, 1}; cy = '{3, 1};
    run_path(1, -1);
    do_start();

    // T4: back-pressure right after the first pair.
    set_str(8'h1B, 8'h1B);
    cx = '{3, 2, 1, 0}; cy = '{3, 2, 1, 0};
    run_path(2, -1);

    // T5: reset in the middle of T2, then T1 again.
    set_str(8'h1B, 8'h18);
    cx = '{3, 2, 1, 0, 0}; cy = '{3, 3, 2, 1, 0};
    run_path(1, 3);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check_reset_state("midreset");
    set_str(8'h1B, 8'h1B);
    cx = '{3, 2, 1, 0}; cy = '{3, 2, 1, 0};
    run_path(1, -1);

    for (int t = 0; t < 40; t++) begin
      set_str(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      gen_path($urandom_range(0, 3) == 0);
      run_path(0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
